uart_rx_led: RTL

UART 8N1 receiver that is the receive-side counterpart of the LED counter's UART transmitter. It recovers bytes from a serial `rx` line and presents each good byte with a one-cycle strobe. The low nibble of the last good byte drives a 4-bit LED output. It sits beside the LED/UART top level so that a host can set the LEDs over the same serial link the counter transmits on.

---
 rtl/uart_rx_led.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_led.sv
// UART 8N1 receiver: recovers bytes from rx and presents each good byte with a one-cycle strobe.
// The low nibble of the last good byte is held on led.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | timing to the middle of the start bit to confirm it
// DATA      | sampling 8 data bits, LSB first, one per bit period
// STOP      | waiting one bit period, then sampling the stop bit
// WAIT_HIGH | framing error seen; wait for the line to return high
module uart_rx_led #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic [3:0] led,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_d;
    logic [3:0]       led_d;
    logic             data_valid_d;
    logic             frame_err_d;
    logic             rx_m;
    logic             rx_s;

    // Two-flop synchronizer; both stages reset to the idle (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            data       <= '0;
            led        <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            data       <= data_d;
            led        <= led_d;
            data_valid <= data_valid_d;
            frame_err  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        data_d       = data;
        led_d        = led;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    // Right shift: the first bit received settles at bit 0.
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d       = shreg_q;
                        led_d        = shreg_q[3:0];
                        data_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end
            end

            S_WAIT_HIGH: begin
                // A held-low line must not be taken as a stream of zero bytes.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule
